// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared types for the RV32I multi-cycle sequencer: state encoding, opcodes,
// ALU and immediate-select codes, and the bundled control-output word.
package ctrl_pkg;

  typedef enum logic [3:0] {
    BOOT, FETCH, DECODE, EXEC_R, EXEC_I, WB_ALU,
    MEM_ADDR, MEM_RD, MEM_WR, WB_MEM, BRANCH, TRAP
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd5
  } alu_op_e;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_sel_e;

  typedef struct packed {
    logic     imem_req;
    logic     ir_we;
    logic     dmem_req;
    logic     dmem_we;
    alu_op_e  alu_ctrl;
    logic     alu_src_b;
    imm_sel_e imm_sel;
    logic     reg_we;
    logic     wb_sel;
    logic     pc_we;
    logic     pc_src;
    logic     retire;
  } ctrl_t;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Control/handshake bundle between the sequencer (master) and the datapath
// plus memories (slave).
interface multi_cycle_ctrl_if;
  logic [31:0] instr;
  logic        eq;
  logic        imem_req;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        ir_we;
  logic [2:0]  ALUctrl;
  logic        alu_src_b;
  logic [1:0]  imm_sel;
  logic        reg_we;
  logic        wb_sel;
  logic        pc_we;
  logic        pc_src;
  logic        retire;
  logic        illegal;

  modport master (
    input  instr, eq, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we, ir_we, ALUctrl, alu_src_b, imm_sel,
           reg_we, wb_sel, pc_we, pc_src, retire, illegal
  );

  modport slave (
    output instr, eq, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we, ir_we, ALUctrl, alu_src_b, imm_sel,
           reg_we, wb_sel, pc_we, pc_src, retire, illegal
  );
endinterface

// File: rtl/multi_cycle_ctrl_alu_decoder.sv
// Combinational opcode/funct decode: ALU operation for R/I forms plus a
// legality bit covering every supported instruction.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output alu_op_e    alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    legal    = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct3)
          F3_ADD: begin
            legal    = (funct7 == F7_BASE) || (funct7 == F7_ALT);
            alu_ctrl = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
          end
          F3_SLT: begin alu_ctrl = ALU_SLT; legal = (funct7 == F7_BASE); end
          F3_OR:  begin alu_ctrl = ALU_OR;  legal = (funct7 == F7_BASE); end
          F3_AND: begin alu_ctrl = ALU_AND; legal = (funct7 == F7_BASE); end
          default: ;
        endcase
      end
      // I-form has no funct7; the upper immediate bits are operand data
      OP_I: begin
        case (funct3)
          F3_ADD: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
          F3_SLT: begin alu_ctrl = ALU_SLT; legal = 1'b1; end
          F3_OR:  begin alu_ctrl = ALU_OR;  legal = 1'b1; end
          F3_AND: begin alu_ctrl = ALU_AND; legal = 1'b1; end
          default: ;
        endcase
      end
      OP_LOAD:   legal = (funct3 == F3_LW);
      OP_STORE:  legal = (funct3 == F3_SW);
      OP_BRANCH: legal = (funct3 == F3_BEQ) || (funct3 == F3_BNE);
      default: ;
    endcase
  end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle RV32I sequencer: fetch/decode/execute/mem/writeback FSM that
// drives datapath selects and memory handshakes; holds no data.
module multi_cycle_ctrl
  import ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  multi_cycle_ctrl_if.master bus
);

  state_e  state_q, state_d;
  logic    illegal_q, illegal_d;
  ctrl_t   c;
  alu_op_e dec_alu;
  logic    dec_legal;

  // A DATA_WIDTH other than the IR width shows up as a width mismatch here
  logic [DATA_WIDTH-1:0] ir;
  assign ir = bus.instr;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_ir;
  assign opcode    = ir[6:0];
  assign funct3    = ir[14:12];
  assign funct7    = ir[31:25];
  assign unused_ir = ^{ir[24:15], ir[11:7]};

  alu_decoder u_dec (
    .opcode   (opcode),
    .funct3   (funct3),
    .funct7   (funct7),
    .alu_ctrl (dec_alu),
    .legal    (dec_legal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BOOT;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:  state_d = FETCH;
      FETCH: if (bus.imem_ack) state_d = DECODE;
      DECODE: begin
        if (!dec_legal) state_d = TRAP;
        else begin
          case (opcode)
            OP_R:               state_d = EXEC_R;
            OP_I:               state_d = EXEC_I;
            OP_LOAD, OP_STORE:  state_d = MEM_ADDR;
            OP_BRANCH:          state_d = BRANCH;
            default:            state_d = TRAP;
          endcase
        end
      end
      EXEC_R, EXEC_I:          state_d = WB_ALU;
      WB_ALU, WB_MEM, BRANCH:  state_d = FETCH;
      MEM_ADDR: state_d = (opcode == OP_STORE) ? MEM_WR : MEM_RD;
      MEM_RD:   if (bus.dmem_ack) state_d = WB_MEM;
      MEM_WR:   if (bus.dmem_ack) state_d = FETCH;
      TRAP:     state_d = TRAP;
      default:  state_d = BOOT;
    endcase
  end

  // Sticky: only reset clears it, independent of where the FSM goes
  assign illegal_d = illegal_q | (state_d == TRAP);

  always_comb begin
    c = '0;
    case (state_q)
      FETCH: begin
        c.imem_req = 1'b1;
        c.ir_we    = bus.imem_ack;
      end
      EXEC_R: c.alu_ctrl = dec_alu;
      EXEC_I: begin
        c.alu_ctrl  = dec_alu;
        c.alu_src_b = 1'b1;
        c.imm_sel   = IMM_I;
      end
      WB_ALU: begin
        c.reg_we = 1'b1;
        c.pc_we  = 1'b1;
        c.retire = 1'b1;
      end
      MEM_ADDR: begin
        c.alu_ctrl  = ALU_ADD;
        c.alu_src_b = 1'b1;
        c.imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
      end
      MEM_RD: c.dmem_req = 1'b1;
      WB_MEM: begin
        c.reg_we = 1'b1;
        c.wb_sel = 1'b1;
        c.pc_we  = 1'b1;
        c.retire = 1'b1;
      end
      MEM_WR: begin
        c.dmem_req = 1'b1;
        c.dmem_we  = 1'b1;
        c.pc_we    = bus.dmem_ack;
        c.retire   = bus.dmem_ack;
      end
      // funct3[0] distinguishes bne from beq
      BRANCH: begin
        c.alu_ctrl = ALU_SUB;
        c.imm_sel  = IMM_B;
        c.pc_we    = 1'b1;
        c.pc_src   = funct3[0] ^ bus.eq;
        c.retire   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.imem_req  = c.imem_req;
  assign bus.ir_we     = c.ir_we;
  assign bus.dmem_req  = c.dmem_req;
  assign bus.dmem_we   = c.dmem_we;
  assign bus.ALUctrl   = c.alu_ctrl;
  assign bus.alu_src_b = c.alu_src_b;
  assign bus.imm_sel   = c.imm_sel;
  assign bus.reg_we    = c.reg_we;
  assign bus.wb_sel    = c.wb_sel;
  assign bus.pc_we     = c.pc_we;
  assign bus.pc_src    = c.pc_src;
  assign bus.retire    = c.retire;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Bench for multi_cycle_ctrl: per-instruction expected output timelines built
// from the instruction class, wait counts and eq, compared every cycle.
module tb_multi_cycle_ctrl;

  typedef enum int {K_R, K_I, K_LW, K_SW, K_BR, K_ILL} kind_e;

  typedef struct packed {
    logic       imem_req;
    logic       ir_we;
    logic       dmem_req;
    logic       dmem_we;
    logic [2:0] alu;
    logic       src_b;
    logic [1:0] imm;
    logic       reg_we;
    logic       wb_sel;
    logic       pc_we;
    logic       pc_src;
    logic       retire;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errs = 0;
  int   checks = 0;
  int   n_ret = 0;
  int   exp_ret = 0;
  obs_t cur;

  multi_cycle_ctrl_if bus();

  multi_cycle_ctrl #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign cur = {bus.imem_req, bus.ir_we, bus.dmem_req, bus.dmem_we, bus.ALUctrl,
                bus.alu_src_b, bus.imm_sel, bus.reg_we, bus.wb_sel, bus.pc_we,
                bus.pc_src, bus.retire, bus.illegal};

  always @(negedge clk) begin
    #1;
    if (bus.retire === 1'b1) n_ret++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset(input string nm);
    #2 rst_n = 1'b0;
    #1 chk({nm, "_rst_async"}, 32'(cur), 32'd0);
    repeat (2) begin
      @(negedge clk);
      bus.imem_ack = 1'($urandom);
      bus.dmem_ack = 1'($urandom);
      #1 chk({nm, "_rst_hold"}, 32'(cur), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.imem_ack = 1'($urandom);
    bus.dmem_ack = 1'($urandom);
    #1 chk({nm, "_boot"}, 32'(cur), 32'd0);
  endtask

  // Starts in the cycle right after BOOT or a retire, i.e. the FETCH cycle.
  task automatic run_instr(input string nm, input kind_e k, input logic [31:0] ins,
                           input logic [2:0] alu, input int fw, input int dw,
                           input logic eqv, input int abort_at);
    obs_t q[$];
    obs_t e;
    int   dack;
    for (int i = 0; i <= fw; i++) begin
      e = '0; e.imem_req = 1'b1; e.ir_we = (i == fw); q.push_back(e);
    end
    q.push_back('0);
    dack = fw + 3 + dw;
    case (k)
      K_R, K_I: begin
        e = '0; e.alu = alu; e.src_b = (k == K_I); q.push_back(e);
        e = '0; e.reg_we = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1; q.push_back(e);
      end
      K_LW: begin
        e = '0; e.src_b = 1'b1; q.push_back(e);
        for (int j = 0; j <= dw; j++) begin e = '0; e.dmem_req = 1'b1; q.push_back(e); end
        e = '0; e.reg_we = 1'b1; e.wb_sel = 1'b1; e.pc_we = 1'b1; e.retire = 1'b1;
        q.push_back(e);
      end
      K_SW: begin
        e = '0; e.src_b = 1'b1; e.imm = 2'd1; q.push_back(e);
        for (int j = 0; j <= dw; j++) begin
          e = '0; e.dmem_req = 1'b1; e.dmem_we = 1'b1;
          e.pc_we = (j == dw); e.retire = (j == dw);
          q.push_back(e);
        end
      end
      K_BR: begin
        e = '0; e.alu = 3'd1; e.imm = 2'd2; e.pc_we = 1'b1; e.retire = 1'b1;
        e.pc_src = ins[12] ? ~eqv : eqv;
        q.push_back(e);
      end
      default: repeat (5) begin e = '0; e.illegal = 1'b1; q.push_back(e); end
    endcase
    bus.eq = eqv;
    foreach (q[i]) begin
      @(negedge clk);
      bus.imem_ack = q[i].imem_req ? (i == fw)   : 1'($urandom);
      bus.dmem_ack = q[i].dmem_req ? (i == dack) : 1'($urandom);
      #1 chk($sformatf("%s_c%0d", nm, i), 32'(cur), 32'(q[i]));
      if (q[i].ir_we) bus.instr = ins;
      if (i == abort_at) begin
        do_reset(nm);
        return;
      end
    end
    if (k == K_ILL) do_reset(nm);
    else exp_ret++;
  endtask

  task automatic gen(input int sel, output kind_e k, output logic [31:0] ins,
                     output logic [2:0] alu);
    logic [4:0]  rd, rs1, rs2;
    logic [11:0] imm;
    logic        b;
    int          m;
    rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    imm = 12'($urandom); b = 1'($urandom); m = $urandom_range(0, 4);
    alu = 3'd0;
    case (sel)
      0, 1, 9: begin
        k = K_R;
        case (m)
          0: begin ins = {7'h00, rs2, rs1, 3'b000, rd, 7'h33}; alu = 3'd0; end
          1: begin ins = {7'h20, rs2, rs1, 3'b000, rd, 7'h33}; alu = 3'd1; end
          2: begin ins = {7'h00, rs2, rs1, 3'b010, rd, 7'h33}; alu = 3'd5; end
          3: begin ins = {7'h00, rs2, rs1, 3'b110, rd, 7'h33}; alu = 3'd3; end
          default: begin ins = {7'h00, rs2, rs1, 3'b111, rd, 7'h33}; alu = 3'd2; end
        endcase
      end
      2, 3: begin
        k = K_I;
        case (m % 4)
          0: begin ins = {imm, rs1, 3'b000, rd, 7'h13}; alu = 3'd0; end
          1: begin ins = {imm, rs1, 3'b010, rd, 7'h13}; alu = 3'd5; end
          2: begin ins = {imm, rs1, 3'b110, rd, 7'h13}; alu = 3'd3; end
          default: begin ins = {imm, rs1, 3'b111, rd, 7'h13}; alu = 3'd2; end
        endcase
      end
      4: begin k = K_LW; ins = {imm, rs1, 3'b010, rd, 7'h03}; end
      5: begin k = K_SW; ins = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23}; end
      6, 7: begin k = K_BR; ins = {imm[11:5], rs2, rs1, 2'b00, b, imm[4:0], 7'h63}; end
      default: begin
        k = K_ILL;
        case (m)
          0: ins = {7'h01, rs2, rs1, 3'b000, rd, 7'h33};
          1: ins = {imm, rs1, 3'b001, rd, 7'h13};
          2: ins = {imm, rs1, 3'b000, rd, 7'h03};
          3: ins = {imm[11:5], rs2, rs1, 3'b100, imm[4:0], 7'h63};
          default: ins = {imm, rs1, 3'b000, rd, 7'h37};
        endcase
      end
    endcase
  endtask

  initial begin
    kind_e       k;
    logic [31:0] ins;
    logic [2:0]  alu;
    int          fw, dw, ab;
    bus.instr = '0; bus.eq = 1'b0; bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;

    @(negedge clk);
    #1 chk("reset", 32'(cur), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("boot", 32'(cur), 32'd0);

    run_instr("rst_fetch", K_R, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 3'd0, 3, 0, 1'b0, 1);
    run_instr("add", K_R, {7'h00, 5'd2, 5'd1, 3'b000, 5'd3, 7'h33}, 3'd0, 0, 0, 1'b0, -1);
    run_instr("sub", K_R, {7'h20, 5'd2, 5'd1, 3'b000, 5'd4, 7'h33}, 3'd1, 0, 0, 1'b0, -1);
    run_instr("lw_w3", K_LW, {12'd8, 5'd1, 3'b010, 5'd5, 7'h03}, 3'd0, 0, 3, 1'b0, -1);
    run_instr("beq", K_BR, {7'd0, 5'd2, 5'd1, 3'b000, 5'd8, 7'h63}, 3'd0, 0, 0, 1'b1, -1);
    run_instr("bne", K_BR, {7'd0, 5'd2, 5'd1, 3'b001, 5'd8, 7'h63}, 3'd0, 0, 0, 1'b1, -1);
    run_instr("sw", K_SW, {7'd0, 5'd2, 5'd1, 3'b010, 5'd4, 7'h23}, 3'd0, 0, 0, 1'b0, -1);
    run_instr("addi", K_I, {12'hFFF, 5'd1, 3'b000, 5'd6, 7'h13}, 3'd0, 1, 0, 1'b0, -1);
    run_instr("trap_ff", K_ILL, 32'hFFFF_FFFF, 3'd0, 0, 0, 1'b0, -1);
    run_instr("rst_memrd", K_LW, {12'd4, 5'd1, 3'b010, 5'd5, 7'h03}, 3'd0, 0, 5, 1'b0, 4);

    for (int n = 0; n < 150; n++) begin
      gen($urandom_range(0, 9), k, ins, alu);
      fw = $urandom_range(0, 2);
      dw = $urandom_range(0, 3);
      ab = ($urandom_range(0, 15) == 0) ? $urandom_range(0, fw + 2) : -1;
      run_instr($sformatf("rnd%0d", n), k, ins, alu, fw, dw, 1'($urandom), ab);
    end

    @(negedge clk);
    #2 chk("retire_cnt", 32'(n_ret), 32'(exp_ret));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
